// File: rtl/rv_dmem_pkg.sv
// Shared types and default configuration for the wait-stated data memory responder.
package rv_dmem_pkg;

    localparam int unsigned DefDpWidth    = 32;
    localparam int unsigned DefDepth      = 1024;
    localparam int unsigned DefWaitCycles = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/rv_dmem_resp_if.sv
// CPU-to-data-memory request/response bus. The be signal exists only when
// RV_DMEM_BYTEEN_EN is defined.
interface rv_dmem_resp_if #(
    parameter int unsigned DPWIDTH = 32
);
    logic                   req;
    logic                   we;
    logic [DPWIDTH-1:0]     addr;
    logic [DPWIDTH-1:0]     wdata;
`ifdef RV_DMEM_BYTEEN_EN
    logic [DPWIDTH/8-1:0]   be;
`endif
    logic [DPWIDTH-1:0]     rdata;
    logic                   ready;
    logic                   err;

`ifdef RV_DMEM_BYTEEN_EN
    modport master (output req, we, addr, wdata, be, input rdata, ready, err);
    modport slave  (input req, we, addr, wdata, be, output rdata, ready, err);
`else
    modport master (output req, we, addr, wdata, input rdata, ready, err);
    modport slave  (input req, we, addr, wdata, output rdata, ready, err);
`endif

endinterface

// File: rtl/rv_dmem_array.sv
// Word-organised storage: synchronous write with per-byte enables, asynchronous read.
module rv_dmem_array #(
    parameter int unsigned DPWIDTH = 32,
    parameter int unsigned DEPTH   = 1024,
    localparam int unsigned NumBytes = DPWIDTH / 8,
    localparam int unsigned AddrW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AddrW-1:0]    waddr,
    input  logic [DPWIDTH-1:0]  wdata,
    input  logic [NumBytes-1:0] be,
    input  logic [AddrW-1:0]    raddr,
    output logic [DPWIDTH-1:0]  rdata
);

    logic [DPWIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rv_dmem_resp.sv
// Data memory responder with WAIT_CYCLES wait states and alignment/range error reporting.
// Byte-enable writes are enabled by defining RV_DMEM_BYTEEN_EN.
module rv_dmem_resp
    import rv_dmem_pkg::*;
#(
    parameter int unsigned DPWIDTH     = DefDpWidth,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
    input logic           clk,
    input logic           rst_n,
    rv_dmem_resp_if.slave bus
);

    localparam int unsigned NumBytes = DPWIDTH / 8;
    localparam int unsigned AddrW    = $clog2(DEPTH);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 enter_resp;

    logic                 we_q;
    logic [DPWIDTH-1:0]   addr_q, wdata_q;
    logic [NumBytes-1:0]  be_q;
    logic [DPWIDTH-1:0]   rdata_q;

    logic [NumBytes-1:0]  be_in;
    logic                 t_we;
    logic [DPWIDTH-1:0]   t_addr, t_wdata, t_word;
    logic [NumBytes-1:0]  t_be;
    logic                 fault;
    logic                 mem_we;
    logic [DPWIDTH-1:0]   mem_rdata;

`ifdef RV_DMEM_BYTEEN_EN
    assign be_in = bus.be;
`else
    assign be_in = '1;
`endif

    // In IDLE the live bus is the transaction (needed when WAIT_CYCLES=0); afterwards the
    // captured copy is, so a dropped req cannot disturb it.
    always_comb begin
        if (state_q == StIdle) begin
            t_we    = bus.we;
            t_addr  = bus.addr;
            t_wdata = bus.wdata;
            t_be    = be_in;
        end else begin
            t_we    = we_q;
            t_addr  = addr_q;
            t_wdata = wdata_q;
            t_be    = be_q;
        end
    end

    assign t_word = t_addr >> 2;
    assign fault  = (t_addr[1:0] != 2'b00) || (t_word >= DPWIDTH'(DEPTH));
    assign mem_we = enter_resp && t_we && !fault;

    rv_dmem_array #(
        .DPWIDTH (DPWIDTH),
        .DEPTH   (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (t_word[AddrW-1:0]),
        .wdata (t_wdata),
        .be    (t_be),
        .raddr (t_word[AddrW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ready = (state_q == StResp);
        bus.err   = (state_q == StResp) && fault;
        bus.rdata = rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (state_q == StIdle && bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            be_q    <= be_in;
        end
    end

    // Only a good read updates rdata; writes and faults leave the last read value visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (enter_resp && !t_we && !fault) begin
            rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Scoreboard bench for rv_dmem_resp: a WAIT_CYCLES=2 instance driven by directed transactions
// and a WAIT_CYCLES=0 instance for back-to-back acceptance.
module tb_rv_dmem_resp;

    localparam int unsigned W = 2;

    typedef struct {
        int          id;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   txn_id;
    logic [3:0] cur_be;
    exp_t sbq[$];

    rv_dmem_resp_if #(.DPWIDTH(32)) bus2 ();
    rv_dmem_resp_if #(.DPWIDTH(32)) bus0 ();

    rv_dmem_resp #(.DPWIDTH(32), .DEPTH(1024), .WAIT_CYCLES(W)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    rv_dmem_resp #(.DPWIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Monitor: every ready pulse on the wait-stated instance is matched against the queue.
    always @(negedge clk) begin
        if (bus2.ready) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready at cycle %0d: got ready=1, required 0", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check($sformatf("txn%0d_err", e.id), {31'd0, bus2.err}, {31'd0, e.exp_err});
                check($sformatf("txn%0d_rdata", e.id), bus2.rdata, e.exp_rd);
                check($sformatf("txn%0d_cycle", e.id), cyc, e.exp_cyc);
            end
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err,
                       input bit drop);
        exp_t e;
        @(posedge clk);
        #1;
        bus2.req   = 1'b1;
        bus2.we    = w;
        bus2.addr  = a;
        bus2.wdata = d;
        cur_be     = b;
`ifdef RV_DMEM_BYTEEN_EN
        bus2.be    = cur_be;
`endif
        e.id      = txn_id;
        e.exp_err = exp_err;
        e.exp_rd  = exp_rd;
        e.exp_cyc = cyc + 1 + int'(W);
        sbq.push_back(e);
        txn_id++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (drop) bus2.req = 1'b0;
            if (bus2.ready) begin
                bus2.req = 1'b0;
                return;
            end
        end
        bus2.req = 1'b0;
        n_chk++;
        n_fail++;
        $display("FAIL txn%0d_timeout: got no ready, required ready within 40 cycles", e.id);
    endtask

    initial begin
        int pulses;
        cyc        = 0;
        n_chk      = 0;
        n_fail     = 0;
        txn_id     = 0;
        cur_be     = 4'hF;
        rst_n      = 1'b0;
        bus2.req   = 1'b0;
        bus2.we    = 1'b0;
        bus2.addr  = '0;
        bus2.wdata = '0;
        bus0.req   = 1'b0;
        bus0.we    = 1'b0;
        bus0.addr  = '0;
        bus0.wdata = '0;
`ifdef RV_DMEM_BYTEEN_EN
        bus2.be    = 4'hF;
        bus0.be    = 4'hF;
`endif
        @(negedge clk);
        check("reset_ready", {31'd0, bus2.ready}, 32'd0);
        check("reset_err", {31'd0, bus2.err}, 32'd0);
        check("reset_rdata", bus2.rdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        txn(1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0, 1'b0);
        txn(1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        txn(1'b0, 32'h13,   32'h0,        4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
        txn(1'b1, 32'h11,   32'h12345678, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
        txn(1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        txn(1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        txn(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
        txn(1'b0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 1'b0, 1'b0);
        txn(1'b1, 32'h20,   32'h0BADC0DE, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0);
        txn(1'b1, 32'hFFC,  32'h13579BDF, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0);
        txn(1'b0, 32'hFFC,  32'h0,        4'hF, 32'h13579BDF, 1'b0, 1'b0);

        // Reset pulse while a write to 0x20 sits in WAIT.
        @(posedge clk);
        #1;
        bus2.req   = 1'b1;
        bus2.we    = 1'b1;
        bus2.addr  = 32'h20;
        bus2.wdata = 32'h5;
        @(posedge clk);
        #1;
        bus2.req = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("abort_rdata_cleared", bus2.rdata, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus2.ready) pulses++;
        end
        check("abort_ready_pulses", pulses, 0);

        txn(1'b0, 32'h20,   32'h0,        4'hF, 32'h0BADC0DE, 1'b0, 1'b0);
        txn(1'b1, 32'h24,   32'h600DF00D, 4'hF, 32'h0BADC0DE, 1'b0, 1'b1);
        txn(1'b0, 32'h24,   32'h0,        4'hF, 32'h600DF00D, 1'b0, 1'b0);
        txn(1'b1, 32'h30,   32'h11223344, 4'hF, 32'h600DF00D, 1'b0, 1'b0);
`ifdef RV_DMEM_BYTEEN_EN
        txn(1'b1, 32'h30,   32'hAABBCCDD, 4'h5, 32'h600DF00D, 1'b0, 1'b0);
        txn(1'b0, 32'h30,   32'h0,        4'hF, 32'h11BB33DD, 1'b0, 1'b0);
        txn(1'b1, 32'h30,   32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0, 1'b0);
        txn(1'b0, 32'h30,   32'h0,        4'hF, 32'h11BB33DD, 1'b0, 1'b0);
`else
        txn(1'b1, 32'h30,   32'hAABBCCDD, 4'hF, 32'h600DF00D, 1'b0, 1'b0);
        txn(1'b0, 32'h30,   32'h0,        4'hF, 32'hAABBCCDD, 1'b0, 1'b0);
`endif

        // Zero-wait instance: one write, then req held high across two reads.
        @(posedge clk);
        #1;
        bus0.req   = 1'b1;
        bus0.we    = 1'b1;
        bus0.addr  = 32'h8;
        bus0.wdata = 32'hA5A55A5A;
        @(posedge clk);
        #1;
        check("w0_write_ready", {31'd0, bus0.ready}, 32'd1);
        bus0.req = 1'b0;
        @(posedge clk);
        #1;
        bus0.req = 1'b1;
        bus0.we  = 1'b0;
        @(posedge clk);
        #1;
        check("w0_c1_ready", {31'd0, bus0.ready}, 32'd1);
        check("w0_c1_err", {31'd0, bus0.err}, 32'd0);
        check("w0_c1_rdata", bus0.rdata, 32'hA5A55A5A);
        @(posedge clk);
        #1;
        check("w0_c2_ready", {31'd0, bus0.ready}, 32'd0);
        @(posedge clk);
        #1;
        check("w0_c3_ready", {31'd0, bus0.ready}, 32'd1);
        check("w0_c3_rdata", bus0.rdata, 32'hA5A55A5A);
        bus0.req = 1'b0;
        @(posedge clk);
        #1;
        check("w0_c4_ready", {31'd0, bus0.ready}, 32'd0);

        repeat (6) @(posedge clk);
        check("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rv_dmem_resp.md
RV_DMEM_RESP -- requirements
Module: rv_dmem_resp

Interface
REQ-001 Parameter DPWIDTH, default 32, SHALL set the data/address width in bits.
REQ-002 Parameter DEPTH, default 1024, SHALL set the number of DPWIDTH-bit words stored.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set the wait states inserted before each response.
REQ-004 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req  input  1  SHALL be the request from the CPU, held high until ready.
REQ-007 we  input  1  SHALL be high for a write and low for a read, qualified by req.
REQ-008 addr  input  DPWIDTH  SHALL be the byte address.
REQ-009 wdata  input  DPWIDTH  SHALL be the write data.
REQ-010 be  input  4  SHALL be the byte enables, present only when RV_DMEM_BYTEEN_EN is defined.
REQ-011 rdata  output  DPWIDTH  SHALL be the read data.
REQ-012 ready  output  1  SHALL be a one-cycle completion strobe.
REQ-013 err  output  1  SHALL be a one-cycle error flag, valid only with ready.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, the block SHALL capture addr/we/wdata(/be) and move to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-016 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit down-counter, then move to RESP.
REQ-017 Latency: req seen in IDLE at cycle N SHALL give ready=1 in exactly cycle N+1+WAIT_CYCLES.
REQ-018 RESP SHALL last one cycle with ready=1, then return to IDLE; no new request is accepted while in RESP.
REQ-019 The write SHALL commit to the array on the edge entering RESP; a read SHALL drive rdata=mem[addr>>2] during RESP.
REQ-020 rdata SHALL hold its last read value outside read responses; writes SHALL NOT change rdata.
REQ-021 An address with addr[1:0]!=0, or with addr>>2 >= DEPTH, SHALL produce err=1 with ready; no write occurs and rdata is unchanged.
REQ-022 Faulting requests SHALL still take the full WAIT_CYCLES latency.
REQ-023 If req drops during WAIT, the captured transaction SHALL still complete normally.
REQ-024 If req stays high through RESP, the next transaction SHALL be accepted in the following IDLE cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, counter=0, ready=0, err=0 and rdata=0.
REQ-026 Reset during WAIT SHALL abort the transaction without any write.
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 With RV_DMEM_BYTEEN_EN defined, the be port SHALL exist and a write SHALL update only the bytes whose be bit is 1; be=0000 completes with no change.
REQ-029 Without RV_DMEM_BYTEEN_EN, the be port SHALL be absent and every write SHALL update the full word.

Structure
REQ-030 Package rv_dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the default width, depth and wait-cycle constants.
REQ-031 Sub-module rv_dmem_array SHALL implement the storage: synchronous write with per-byte enable, asynchronous read.

Verification
REQ-032 Read-after-write, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 at cycle 0 -> ready at cycle 3, err=0; read 0x10 -> rdata=0xDEADBEEF with ready.
REQ-033 Misaligned access: read 0x13 -> ready+err after 3 cycles; write 0x11 -> err=1, and a later read of 0x10 is unchanged.
REQ-034 Out of range, DEPTH=1024: write 0x1000 -> err=1, and word 0 is not corrupted.
REQ-035 Reset abort: rst_n low one cycle during WAIT of a write of 0x5 to 0x20 -> ready never pulses, and a later read of 0x20 returns the old value.
REQ-036 Byte enables (macro on): word 0x11223344, write 0xAABBCCDD with be=0101 -> read returns 0x11BB33DD.
REQ-037 Back-to-back, WAIT_CYCLES=0: req held high for two reads -> ready in cycles 1 and 3, low in cycle 2.
